tug_score_keeper: RTL and testbench

Referee/scoreboard for the Digital Tug-of-War game: reads the 15-bit rope LED vector produced by the game core, encodes the rope position, and detects when the rope reaches either end. It counts rounds won per player and declares a match winner after a configurable number of round wins. It sits downstream of the game core on the `led` bus and shares the `S` start level with it.

---
 rtl/tug_pkg.sv | 18 +
 rtl/tug_score_keeper_if.sv | 32 +++
 rtl/tug_pos_encoder.sv | 22 ++
 rtl/tug_score_keeper.sv | 160 ++++++++++++++++
 tb/tb_tug_score_keeper.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/tug_pkg.sv
// Shared constants and types for the tug-of-war score keeper.
//   LED_W / POS_W : rope vector width and encoded index width
//   *_IDX         : rope indices of the centre and the two ends
//   tug_state_e   : referee FSM state encoding (visible on the debug port)
package tug_pkg;
  localparam int LED_W      = 15;
  localparam int POS_W      = 4;
  localparam int CENTER_IDX = 7;
  localparam int LEFT_IDX   = 14;
  localparam int RIGHT_IDX  = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    ROUND_END = 2'd2,
    MATCH_END = 2'd3
  } tug_state_e;
endpackage

// File: rtl/tug_score_keeper_if.sv
// Bus between the game side and the score keeper.
//   S, led          : start level and rope vector (game side -> keeper)
//   pos..state      : referee results (keeper -> observer)
// master = game/observer side, slave = score keeper.
interface tug_score_keeper_if;
  import tug_pkg::*;

  logic                 S;
  logic [LED_W-1:0]     led;
  logic [POS_W-1:0]     pos;
  logic                 pos_valid;
  logic                 pattern_err;
  logic [3:0]           score_l;
  logic [3:0]           score_r;
  logic                 round_win_l;
  logic                 round_win_r;
  logic                 match_over;
  logic                 match_winner;
  logic [1:0]           state;

  modport master (
    output S, led,
    input  pos, pos_valid, pattern_err, score_l, score_r,
           round_win_l, round_win_r, match_over, match_winner, state
  );

  modport slave (
    input  S, led,
    output pos, pos_valid, pattern_err, score_l, score_r,
           round_win_l, round_win_r, match_over, match_winner, state
  );
endinterface

// File: rtl/tug_pos_encoder.sv
// Combinational one-hot to index encoder for the rope vector.
//   led     : rope vector
//   idx     : index of the set bit (meaningless unless one_hot)
//   one_hot : exactly one bit of led is set
module tug_pos_encoder
  import tug_pkg::*;
(
  input  logic [LED_W-1:0] led,
  output logic [POS_W-1:0] idx,
  output logic             one_hot
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (led[i]) idx = POS_W'(i);
    end
    // x & (x-1) clears the lowest set bit; zero result means at most one bit.
    one_hot = (led != '0) && ((led & (led - 1'b1)) == '0);
  end

endmodule

// File: rtl/tug_score_keeper.sv
// Referee for the tug-of-war game: registers the encoded rope position,
// filters end-of-rope patterns over HOLD_CYCLES, keeps per-player round
// scores and declares a match winner at WIN_ROUNDS round wins.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of tug_score_keeper_if (S, led in; results out)
module tug_score_keeper
  import tug_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int WIN_ROUNDS  = 3
) (
  input logic              clk,
  input logic              rst,
  tug_score_keeper_if.slave bus
);

  localparam logic [3:0]       HOLD_LIM = 4'(HOLD_CYCLES);
  localparam logic [3:0]       WIN_LIM  = 4'(WIN_ROUNDS);
  localparam logic [POS_W-1:0] POS_C    = POS_W'(CENTER_IDX);
  localparam logic [POS_W-1:0] POS_L    = POS_W'(LEFT_IDX);
  localparam logic [POS_W-1:0] POS_R    = POS_W'(RIGHT_IDX);

  logic [POS_W-1:0] enc_idx;
  logic             enc_one_hot;

  logic [POS_W-1:0] pos_q, pos_d;
  logic             pos_valid_q, pos_valid_d;
  logic             pattern_err_q, pattern_err_d;
  logic             s_q, s_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic [3:0]       score_l_q, score_l_d;
  logic [3:0]       score_r_q, score_r_d;
  logic             win_l_q, win_l_d;
  logic             win_r_q, win_r_d;
  logic             winner_q, winner_d;
  tug_state_e       state_q, state_d;

  logic s_rise, at_left, at_right, at_center;

  tug_pos_encoder u_enc (
    .led     (bus.led),
    .idx     (enc_idx),
    .one_hot (enc_one_hot)
  );

  // Position stage: invalid patterns keep the last good index.
  always_comb begin
    pos_d         = enc_one_hot ? enc_idx : pos_q;
    pos_valid_d   = enc_one_hot;
    pattern_err_d = ~enc_one_hot;
    s_d           = bus.S;
  end

  // All FSM decisions look at the registered position, hence the
  // one-cycle lag behind led.
  assign s_rise    = bus.S & ~s_q;
  assign at_left   = pos_valid_q && (pos_q == POS_L);
  assign at_right  = pos_valid_q && (pos_q == POS_R);
  assign at_center = pos_valid_q && (pos_q == POS_C);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    win_l_d    = 1'b0;
    win_r_d    = 1'b0;
    winner_d   = winner_q;

    case (state_q)
      IDLE: begin
        if (s_rise) begin
          score_l_d = '0;
          score_r_d = '0;
          state_d   = PLAY;
        end
      end

      PLAY: begin
        if (at_left || at_right) begin
          // The cycle that would bring the count to HOLD_LIM is the win.
          if (hold_cnt_q == HOLD_LIM - 4'd1) begin
            state_d = ROUND_END;
            if (at_left) begin
              win_l_d = 1'b1;
              if (score_l_q < WIN_LIM) score_l_d = score_l_q + 4'd1;
              if (score_l_q + 4'd1 == WIN_LIM) begin
                state_d  = MATCH_END;
                winner_d = 1'b0;
              end
            end else begin
              win_r_d = 1'b1;
              if (score_r_q < WIN_LIM) score_r_d = score_r_q + 4'd1;
              if (score_r_q + 4'd1 == WIN_LIM) begin
                state_d  = MATCH_END;
                winner_d = 1'b1;
              end
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end
      end

      ROUND_END: begin
        if (at_center) state_d = PLAY;
      end

      MATCH_END: begin
        if (s_rise) begin
          score_l_d = '0;
          score_r_d = '0;
          state_d   = PLAY;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q         <= POS_C;
      pos_valid_q   <= 1'b0;
      pattern_err_q <= 1'b0;
      s_q           <= 1'b0;
      hold_cnt_q    <= '0;
      score_l_q     <= '0;
      score_r_q     <= '0;
      win_l_q       <= 1'b0;
      win_r_q       <= 1'b0;
      winner_q      <= 1'b0;
      state_q       <= IDLE;
    end else begin
      pos_q         <= pos_d;
      pos_valid_q   <= pos_valid_d;
      pattern_err_q <= pattern_err_d;
      s_q           <= s_d;
      hold_cnt_q    <= hold_cnt_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      win_l_q       <= win_l_d;
      win_r_q       <= win_r_d;
      winner_q      <= winner_d;
      state_q       <= state_d;
    end
  end

  assign bus.pos          = pos_q;
  assign bus.pos_valid    = pos_valid_q;
  assign bus.pattern_err  = pattern_err_q;
  assign bus.score_l      = score_l_q;
  assign bus.score_r      = score_r_q;
  assign bus.round_win_l  = win_l_q;
  assign bus.round_win_r  = win_r_q;
  assign bus.match_over   = (state_q == MATCH_END);
  assign bus.match_winner = winner_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_tug_score_keeper.sv
module tb_tug_score_keeper;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  tug_score_keeper_if bus ();

  tug_score_keeper #(.HOLD_CYCLES(4), .WIN_ROUNDS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] led;
    logic [3:0]  pos;
    logic        valid;
    logic        err;
  } vec_t;

  typedef struct {
    logic [3:0] pos;
    logic       valid;
    logic       err;
  } exp_t;

  vec_t tbl [10];
  exp_t sb [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven 1ns after the edge and outputs sampled there too,
  // so after step() outputs reflect the inputs driven before it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pos"},     bus.pos, 7);
    chk({tag, "_valid"},   bus.pos_valid, 0);
    chk({tag, "_err"},     bus.pattern_err, 0);
    chk({tag, "_score_l"}, bus.score_l, 0);
    chk({tag, "_score_r"}, bus.score_r, 0);
    chk({tag, "_win_l"},   bus.round_win_l, 0);
    chk({tag, "_win_r"},   bus.round_win_r, 0);
    chk({tag, "_mover"},   bus.match_over, 0);
    chk({tag, "_winner"},  bus.match_winner, 0);
    chk({tag, "_state"},   bus.state, 0);
  endtask

  // Holds an end pattern for 4 cycles, then returns to centre; the pulse
  // must appear exactly on the edge that samples the 4th end position.
  task automatic run_end(input bit right, input string tag);
    bus.led = right ? 15'h0001 : 15'h4000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk({tag, "_early_l"}, bus.round_win_l, 0);
      chk({tag, "_early_r"}, bus.round_win_r, 0);
    end
    bus.led = 15'h0080;
    step();
    chk({tag, "_pulse_l"}, bus.round_win_l, right ? 0 : 1);
    chk({tag, "_pulse_r"}, bus.round_win_r, right ? 1 : 0);
  endtask

  initial begin
    int err_cycles;
    int pulses;
    exp_t e;

    tbl[0] = '{15'h0080, 4'd7,  1'b1, 1'b0};
    tbl[1] = '{15'h0000, 4'd7,  1'b0, 1'b1};
    tbl[2] = '{15'h4000, 4'd14, 1'b1, 1'b0};
    tbl[3] = '{15'h0003, 4'd14, 1'b0, 1'b1};
    tbl[4] = '{15'h0001, 4'd0,  1'b1, 1'b0};
    tbl[5] = '{15'h0400, 4'd10, 1'b1, 1'b0};
    tbl[6] = '{15'h7FFF, 4'd10, 1'b0, 1'b1};
    tbl[7] = '{15'h0002, 4'd1,  1'b1, 1'b0};
    tbl[8] = '{15'h2000, 4'd13, 1'b1, 1'b0};
    tbl[9] = '{15'h0080, 4'd7,  1'b1, 1'b0};

    // Reset with a valid centre pattern present: reset must win.
    rst = 1'b1;
    bus.S = 1'b0;
    bus.led = 15'h0080;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Position encoder vectors while idle (S low, FSM must stay put).
    for (int i = 0; i < 10; i++) begin
      bus.led = tbl[i].led;
      sb.push_back('{tbl[i].pos, tbl[i].valid, tbl[i].err});
      step();
      e = sb.pop_front();
      chk($sformatf("vec%0d_pos", i),   bus.pos, e.pos);
      chk($sformatf("vec%0d_valid", i), bus.pos_valid, e.valid);
      chk($sformatf("vec%0d_err", i),   bus.pattern_err, e.err);
      chk($sformatf("vec%0d_state", i), bus.state, 0);
    end

    // Start.
    bus.S = 1'b1;
    step();
    chk("start_state", bus.state, 1);
    chk("start_score_l", bus.score_l, 0);
    chk("start_score_r", bus.score_r, 0);
    chk("start_pos", bus.pos, 7);
    chk("start_valid", bus.pos_valid, 1);

    // Left round win, then back to centre resumes play.
    run_end(1'b0, "lwin");
    chk("lwin_score_l", bus.score_l, 1);
    chk("lwin_state", bus.state, 2);
    step();
    chk("lwin_pulse_once", bus.round_win_l, 0);
    chk("lwin_resume", bus.state, 1);

    // Glitch filter: 3 + gap + 3 end cycles never reach the hold count.
    err_cycles = 0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 3 || (k >= 4 && k < 7)) bus.led = 15'h0001;
      else if (k == 3)                bus.led = 15'h0000;
      else                            bus.led = 15'h0080;
      step();
      err_cycles += int'(bus.pattern_err);
      pulses += int'(bus.round_win_r) + int'(bus.round_win_l);
    end
    chk("glitch_err_cycles", err_cycles, 1);
    chk("glitch_pulses", pulses, 0);
    chk("glitch_score_r", bus.score_r, 0);
    chk("glitch_state", bus.state, 1);

    // Three right wins end the match.
    run_end(1'b1, "r1");
    chk("r1_score", bus.score_r, 1);
    step();
    chk("r1_resume", bus.state, 1);
    run_end(1'b1, "r2");
    chk("r2_score", bus.score_r, 2);
    step();
    chk("r2_resume", bus.state, 1);
    run_end(1'b1, "r3");
    chk("r3_score", bus.score_r, 3);
    chk("r3_state", bus.state, 3);
    chk("r3_match_over", bus.match_over, 1);
    chk("r3_winner", bus.match_winner, 1);
    chk("r3_score_l", bus.score_l, 1);

    // Scores frozen in MATCH_END.
    bus.led = 15'h0001;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      pulses += int'(bus.round_win_r);
    end
    chk("frozen_pulses", pulses, 0);
    chk("frozen_score_r", bus.score_r, 3);
    chk("frozen_state", bus.state, 3);

    // Restart: S 1-0-1 in MATCH_END.
    bus.led = 15'h0080;
    bus.S = 1'b0;
    step();
    chk("restart_wait", bus.state, 3);
    bus.S = 1'b1;
    step();
    chk("restart_state", bus.state, 1);
    chk("restart_score_l", bus.score_l, 0);
    chk("restart_score_r", bus.score_r, 0);
    chk("restart_mover", bus.match_over, 0);
    bus.S = 1'b0;
    step();
    bus.S = 1'b1;
    step();
    chk("s_edge_in_play", bus.state, 1);

    // Reset mid-round with the hold counter at 2; S stays high throughout.
    bus.led = 15'h4000;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk_reset_vals("midrst");
    rst = 1'b0;
    bus.led = 15'h0080;
    step();
    chk("held_s_edge_after_rst", bus.state, 1);
    step();
    chk("held_s_single_edge", bus.state, 1);
    chk("post_rst_pos", bus.pos, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
